// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side byte packer.
package fifo_rd_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned NB_DEF = 4;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } rd_state_e;

  // Width needed to hold a lane count in the range 0..nb
  function automatic int unsigned lane_idx_w(input int unsigned nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/rd_lane_reg.sv
// NB x DW lane bank: per-lane write enable, bulk clear, registered lane-valid mask.
module rd_lane_reg
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned NB = NB_DEF,
  parameter int unsigned CW = lane_idx_w(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [CW-1:0]    wr_idx_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             clr_i,
  output logic [DW*NB-1:0] data_o,
  output logic [NB-1:0]    keep_o
);

  logic [NB-1:0][DW-1:0] lane_q;
  logic [NB-1:0]         keep_q;
  logic [NB-1:0]         lane_we;

  always_comb begin
    lane_we = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_we[i] = wr_en_i && (wr_idx_i == CW'(i));
    end
  end

  // Lanes fill in index order, so keep stays contiguous from bit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
      keep_q <= '0;
    end else if (clr_i) begin
      lane_q <= '0;
      keep_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (lane_we[i]) begin
          lane_q[i] <= wr_data_i;
          keep_q[i] <= 1'b1;
        end
      end
    end
  end

  assign data_o = lane_q;
  assign keep_o = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the byte FIFO and packs NB bytes into one wide word on a valid/ready port.
// Define FIFO_RD_CKSUM_EN to add the out_cksum port (running byte sum of the word).
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned NB = NB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic             flush,
  output logic [DW*NB-1:0] out_data,
  output logic [NB-1:0]    out_keep,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_RD_CKSUM_EN
  ,
  output logic [DW-1:0]    out_cksum
`endif
);

  localparam int unsigned CW = lane_idx_w(NB);

  rd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          valid_q, valid_d;
  logic [CW:0]   fill_lvl;
  logic          capture;
  logic          handshake;
  logic          rd;

  // Lanes already filled plus the byte still in flight from last cycle's pop
  assign fill_lvl = {1'b0, cnt_q} + (CW+1)'(pend_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd        = 1'b0;
    capture   = pend_q;
    handshake = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (capture && (cnt_q == CW'(NB - 1))) begin
          state_d = ST_OUT;
        end else if (flush && (fill_lvl != '0)) begin
          state_d = pend_q ? ST_DRAIN : ST_OUT;
        end else begin
          rd = !fifo_empty && (fill_lvl < (CW+1)'(NB));
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (capture) cnt_d = cnt_q + CW'(1);
    if (handshake) cnt_d = '0;
    pend_d  = rd;
    valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  // Pop strobe is masked in reset so nothing leaves the FIFO while the lanes are cleared
  assign fifo_read = rst && rd;
  assign out_valid = valid_q;

  rd_lane_reg #(
    .DW(DW),
    .NB(NB),
    .CW(CW)
  ) u_lanes (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (capture),
    .wr_idx_i (cnt_q),
    .wr_data_i(fifo_dout),
    .clr_i    (handshake),
    .data_o   (out_data),
    .keep_o   (out_keep)
  );

`ifdef FIFO_RD_CKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (handshake) cksum_d = '0;
    else if (capture) cksum_d = cksum_q + fifo_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cksum_q <= '0;
    else cksum_q <= cksum_d;
  end

  assign out_cksum = cksum_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a behavioural byte FIFO on the read port.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned NB = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [7:0]  ck;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read;
  logic          flush = 1'b0;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef FIFO_RD_CKSUM_EN
  logic [DW-1:0] out_cksum;
`endif

  logic [7:0] fifo_q[$];
  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       tmo = 1'b0;
  logic       exp_idle = 1'b0;
  logic       exp_nopop = 1'b0;
  logic       prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DW(DW), .NB(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_RD_CKSUM_EN
    ,
    .out_cksum (out_cksum)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t pack_bytes(input logic [31:0] b, input int n);
    exp_t e;
    e.data = '0;
    e.keep = '0;
    e.ck   = '0;
    for (int i = 0; i < n; i++) begin
      e.data[i*8 +: 8] = b[i*8 +: 8];
      e.keep[i]        = 1'b1;
      e.ck             = e.ck + b[i*8 +: 8];
    end
    return e;
  endfunction

  // FIFO model: data appears the edge after a pop; empty flag updates on the clock
  always @(posedge clk) begin
    if (rst && fifo_read && !fifo_empty && (fifo_q.size() > 0)) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rst_valid", 64'(out_valid), 64'(0));
      check_eq("rst_read", 64'(fifo_read), 64'(0));
      check_eq("rst_data", 64'(out_data), 64'(0));
      check_eq("rst_keep", 64'(out_keep), 64'(0));
`ifdef FIFO_RD_CKSUM_EN
      check_eq("rst_cksum", 64'(out_cksum), 64'(0));
`endif
      prev_stall <= 1'b0;
    end else begin
      if (fifo_empty) check_eq("rd_while_empty", 64'(fifo_read), 64'(0));
      if (out_valid) check_eq("rd_in_out", 64'(fifo_read), 64'(0));
      if (exp_idle) check_eq("valid_idle", 64'(out_valid), 64'(0));
      if (exp_nopop) check_eq("pop_on_flush", 64'(fifo_read), 64'(0));
      if (prev_stall && out_valid) check_eq("stall_data", 64'(out_data), 64'(prev_data));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'(out_valid), 64'(0));
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("word_data", 64'(out_data), 64'(mon_e.data));
          check_eq("word_keep", 64'(out_keep), 64'(mon_e.keep));
`ifdef FIFO_RD_CKSUM_EN
          check_eq("word_cksum", 64'(out_cksum), 64'(mon_e.ck));
`endif
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
    check_eq("timeout", 64'(tmo), 64'(0));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] b);
    for (int i = 0; i < 4; i++) fifo_q.push_back(b[i*8 +: 8]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 200)) begin
      tick(1);
      n++;
    end
    if (sb_q.size() != 0) tmo = 1'b1;
    tick(3);
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b1;
    tick(2);

    // Full word, downstream always ready
    out_ready = 1'b1;
    sb_q.push_back('{data: 32'h24510F94, keep: 4'b1111, ck: 8'h18});
    push4(32'h24510F94);
    wait_drain();

    // Output stall with a second word queued behind it
    out_ready = 1'b0;
    sb_q.push_back(pack_bytes(32'h04030201, 4));
    sb_q.push_back('{data: 32'h05060708, keep: 4'b1111, ck: 8'h1A});
    push4(32'h04030201);
    push4(32'h05060708);
    n = 0;
    while (!out_valid && (n < 50)) begin
      tick(1);
      n++;
    end
    if (!out_valid) tmo = 1'b1;
    tick(5);
    out_ready = 1'b1;
    wait_drain();

    // Partial flush while the second byte is in flight; third byte must wait
    sb_q.push_back('{data: 32'h0000F367, keep: 4'b0011, ck: 8'h5A});
    sb_q.push_back(pack_bytes(32'hB3B2B1AA, 4));
    fifo_q.push_back(8'h67);
    fifo_q.push_back(8'hF3);
    fifo_q.push_back(8'hAA);
    tick(3);
    flush     = 1'b1;
    exp_nopop = 1'b1;
    tick(1);
    flush     = 1'b0;
    exp_nopop = 1'b0;
    tick(6);
    fifo_q.push_back(8'hB1);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hB3);
    wait_drain();

    // Flush with nothing buffered is ignored
    exp_idle = 1'b1;
    flush    = 1'b1;
    tick(1);
    flush    = 1'b0;
    tick(6);

    // FIFO runs dry mid-word; partial lanes must be kept
    fifo_q.push_back(8'hC1);
    fifo_q.push_back(8'hC2);
    tick(8);
    exp_idle = 1'b0;
    sb_q.push_back(pack_bytes(32'hC4C3C2C1, 4));
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'hC4);
    wait_drain();

    // Reset after two captures; stale lanes must not leak into the next word
    push4(32'hA4A3A2A1);
    tick(4);
    rst = 1'b0;
    fifo_q.delete();
    tick(3);
    rst = 1'b1;
    tick(2);
    sb_q.push_back('{data: 32'h44332211, keep: 4'b1111, ck: 8'hAA});
    push4(32'h44332211);
    wait_drain();

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
